// File: rtl/formula_pipe_credit_buffer.sv
// formula_pipe_credit_buffer
// Credit-gated issue wrapper and result FIFO for a no-backpressure formula
// pipeline. Arguments may only be issued while a free credit exists, so every
// in-flight result is guaranteed a FIFO slot. Results are buffered and
// presented downstream first-word-fall-through on a valid/ready handshake.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst        : synchronous active-low reset
//   up_vld     : producer has an argument set to issue
//   up_rdy     : issue permitted this cycle (credits != 0)
//   issue      : up_vld & up_rdy, drives the pipeline arg_vld
//   res_vld    : pipeline result valid
//   res        : pipeline result data
//   down_vld   : FIFO head valid
//   down_data  : FIFO head data
//   down_rdy   : consumer accepts the head
//   credits    : free credits, 0..DEPTH
//   count      : FIFO occupancy, 0..DEPTH
//   overflow   : sticky flag, a result arrived with the FIFO full and no pop
module formula_pipe_credit_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_vld,
  output logic                     up_rdy,
  output logic                     issue,
  input  logic                     res_vld,
  input  logic [WIDTH-1:0]         res,
  output logic                     down_vld,
  output logic [WIDTH-1:0]         down_data,
  input  logic                     down_rdy,
  output logic [$clog2(DEPTH):0]   credits,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    credits_r;
  logic             overflow_r;

  logic pop_s;
  logic full_s;
  logic push_ok_s;
  logic drop_s;

  // up_rdy depends only on the registered credit count, never on up_vld/down_rdy.
  assign up_rdy    = (credits_r != ZERO_C);
  assign issue     = up_vld & up_rdy;
  assign down_vld  = (count_r != ZERO_C);
  assign down_data = mem_r[rd_ptr_r];
  assign credits   = credits_r;
  assign count     = count_r;
  assign overflow  = overflow_r;

  assign pop_s     = down_vld & down_rdy;
  assign full_s    = (count_r == DEPTH_C);
  // When full, a simultaneous pop frees the slot at rd_ptr == wr_ptr, so the
  // push lands exactly in the slot being vacated.
  assign push_ok_s = res_vld & (~full_s | pop_s);
  assign drop_s    = res_vld & full_s & ~pop_s;

  // Result storage; not cleared by reset since pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst && push_ok_s) begin
      mem_r[wr_ptr_r] <= res;
    end
  end

  // Pointers, occupancy, credits and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_C;
      credits_r  <= DEPTH_C;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end

      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase

      // A pop can arrive with all credits free (results from before a reset),
      // so the increment saturates at DEPTH.
      case ({issue, pop_s})
        2'b10:   credits_r <= credits_r - ONE_C;
        2'b01:   credits_r <= (credits_r == DEPTH_C) ? credits_r : credits_r + ONE_C;
        default: credits_r <= credits_r;
      endcase

      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_formula_pipe_credit_buffer.sv
// Self-checking bench for formula_pipe_credit_buffer. A driver issues stimulus
// at the falling edge; a monitor, shortly before each rising edge, compares the
// DUT against a queue-based reference model and updates that model.
module tb_formula_pipe_credit_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             up_vld = 1'b0;
  logic             up_rdy;
  logic             issue;
  logic             res_vld = 1'b0;
  logic [WIDTH-1:0] res = '0;
  logic             down_vld;
  logic [WIDTH-1:0] down_data;
  logic             down_rdy = 1'b0;
  logic [3:0]       credits;
  logic [3:0]       count;
  logic             overflow;

  formula_pipe_credit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy), .issue(issue),
    .res_vld(res_vld), .res(res), .down_vld(down_vld), .down_data(down_data),
    .down_rdy(down_rdy), .credits(credits), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] val;
  } pipe_t;

  pipe_t       pipe_q[$];    // bench pipeline: results scheduled by cycle
  logic [31:0] fifo_m[$];    // reference FIFO contents (expected output order)
  int          m_credits = DEPTH;
  bit          m_ovf = 1'b0;
  bit          m_valid = 1'b0;
  int          cyc = 0;
  int          lat = 49;
  int          iss_cnt = 0;
  int          pop_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          pop_now;
  bit          iss_now;

  function automatic logic [31:0] isqrt(input logic [31:0] a);
    longint r = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(a)) r = t;
    end
    return r[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor and reference model, evaluated just before each rising edge.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      fifo_m.delete();
      pipe_q.delete();
      m_credits = DEPTH;
      m_ovf     = 1'b0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      chk("credits", 32'(credits), 32'(m_credits));
      chk("count", 32'(count), 32'(fifo_m.size()));
      chk("up_rdy", 32'(up_rdy), 32'(m_credits != 0));
      chk("down_vld", 32'(down_vld), 32'(fifo_m.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      iss_now = up_vld && (m_credits != 0);
      chk("issue", 32'(issue), 32'(iss_now));
      if (down_vld && fifo_m.size() > 0) chk("down_data", down_data, fifo_m[0]);
      pop_now = down_rdy && (fifo_m.size() > 0);
      if (res_vld) begin
        if (fifo_m.size() < DEPTH || pop_now) fifo_m.push_back(res);
        else m_ovf = 1'b1;
      end
      if (pop_now) begin
        void'(fifo_m.pop_front());
        pop_cnt++;
      end
      if (iss_now) begin
        pipe_q.push_back('{due: cyc + lat, val: isqrt($urandom)});
        iss_cnt++;
      end
      m_credits = m_credits - (iss_now ? 1 : 0) + (pop_now ? 1 : 0);
      if (m_credits > DEPTH) m_credits = DEPTH;
    end
    cyc++;
  end

  task automatic drive(input logic uv, input logic dr, input logic fv);
    @(negedge clk);
    rst      = 1'b1;
    up_vld   = uv;
    down_rdy = dr;
    res_vld  = 1'b0;
    if (fv) begin
      res_vld = 1'b1;
      res     = $urandom;
    end else if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
      res_vld = 1'b1;
      res     = pipe_q[0].val;
      void'(pipe_q.pop_front());
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst      = 1'b0;
      up_vld   = 1'($urandom);
      down_rdy = 1'($urandom);
      res_vld  = 1'($urandom);
      res      = $urandom;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_credits"}, 32'(credits), 32'd8);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_down_vld"}, 32'(down_vld), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_up_rdy"}, 32'(up_rdy), 32'd1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((fifo_m.size() > 0 || pipe_q.size() > 0) && n < max) begin
      drive(1'b0, 1'b1, 1'b0);
      n++;
    end
    drive(1'b0, 1'b1, 1'b0);
    n_chk++;
    if (n >= max) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d queued expected 0", fifo_m.size() + pipe_q.size());
    end
  endtask

  initial begin
    int i0;
    int p0;
    int n;

    // Reset with toggling inputs.
    do_reset(3);
    settle();
    check_reset_state("reset");

    // Streaming with a long pipeline: credits limit issue to DEPTH.
    lat = 49;
    i0 = iss_cnt;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
    settle();
    chk("stream_issues", 32'(iss_cnt - i0), 32'd8);
    chk("stream_up_rdy", 32'(up_rdy), 32'd0);
    drain(300);
    chk("stream_overflow", 32'(overflow), 32'd0);

    // Stalled consumer fills the FIFO to exactly DEPTH.
    lat = 5;
    do_reset(1);
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, 1'b0);
    settle();
    chk("stall_count", 32'(count), 32'd8);
    chk("stall_credits", 32'(credits), 32'd0);
    chk("stall_up_rdy", 32'(up_rdy), 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    settle();
    chk("pop1_count", 32'(count), 32'd7);
    chk("pop1_credits", 32'(credits), 32'd1);
    chk("pop1_up_rdy", 32'(up_rdy), 32'd1);

    // Full FIFO with push + pop + issue in the same cycle.
    drive(1'b0, 1'b0, 1'b1);
    settle();
    chk("simul_pre_count", 32'(count), 32'd8);
    drive(1'b1, 1'b1, 1'b1);
    settle();
    chk("simul_count", 32'(count), 32'd8);
    chk("simul_credits", 32'(credits), 32'd1);
    drain(100);

    // Pointer wrap with a randomly stalling consumer.
    lat = 3;
    i0 = iss_cnt;
    p0 = pop_cnt;
    n  = 0;
    while (iss_cnt - i0 < 3 * DEPTH + 3 && n < 1000) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    drain(200);
    chk("wrap_issues", 32'(iss_cnt - i0), 32'd27);
    chk("wrap_pops", 32'(pop_cnt - p0), 32'd27);

    // Overflow: push into a full FIFO with no pop.
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    settle();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
    settle();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of traffic.
    lat = 4;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
    do_reset(1);
    settle();
    check_reset_state("midrst");
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
